// File: rtl/mmio_timer_pkg.sv
// Shared types and register map for the MMIO timer and its bus responder FSM.
package mmio_timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mmio_state_t;

   localparam int TMR_WIN_BITS = 5;

   localparam logic [4:0] TMR_CTRL    = 5'h00;
   localparam logic [4:0] TMR_COUNT   = 5'h08;
   localparam logic [4:0] TMR_COMPARE = 5'h10;
   localparam logic [4:0] TMR_STATUS  = 5'h18;

   localparam int CTRL_EN          = 0;
   localparam int CTRL_IRQ_EN      = 1;
   localparam int CTRL_AUTO_RELOAD = 2;

   localparam logic [63:0] COMPARE_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

   function automatic logic offset_aligned(input logic [4:0] off);
      return (off[2:0] == 3'd0);
   endfunction

endpackage

// File: rtl/mmio_slave_fsm.sv
// Window decode and fixed-latency request/complete handshake for an MMIO responder.
module mmio_slave_fsm
   import mmio_timer_pkg::*;
#(
   parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_0001_0000,
   parameter int          WAIT_CYCLES = 1,
   parameter int          WIN_BITS    = 5
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [63:0]         addr_i,
   input  logic                req_i,
   input  logic                is_write_i,
   output logic                d_valid_o,
   output logic                d_ready_o,
   output logic                wr_strobe_o,
   output logic                rd_strobe_o,
   output logic [WIN_BITS-1:0] offset_o
);

   localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   mmio_state_t         state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [WIN_BITS-1:0] offset_q, offset_d;
   logic                is_write_q, is_write_d;
   logic                hit_s;

   assign hit_s     = (addr_i[63:WIN_BITS] == BASE_ADDR[63:WIN_BITS]);
   assign d_valid_o = req_i & hit_s;

   // State register with transaction context
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         offset_q   <= {WIN_BITS{1'b0}};
         is_write_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         offset_q   <= offset_d;
         is_write_q <= is_write_d;
      end
   end

   // Next-state logic; a withdrawn request during WAIT aborts silently
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      offset_d   = offset_q;
      is_write_d = is_write_q;
      case (state_q)
         IDLE: begin
            if (d_valid_o) begin
               offset_d   = addr_i[WIN_BITS-1:0];
               is_write_d = is_write_i;
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
                  cnt_d   = 4'd0;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (!d_valid_o) begin
               state_d = IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Completion pulse and access strobes, all decoded from registered state
   always_comb begin
      d_ready_o   = (state_q == RESP);
      wr_strobe_o = (state_q == RESP) & is_write_q;
      rd_strobe_o = (state_q == RESP) & ~is_write_q;
      offset_o    = offset_q;
   end

endmodule

// File: rtl/mmio_timer.sv
// MMIO timer: 64-bit free-running counter with compare match, auto-reload and level irq.
module mmio_timer
   import mmio_timer_pkg::*;
#(
   parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_0001_0000,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [63:0] addr,
   input  logic [63:0] wdata,
   input  logic [2:0]  load_type,
   input  logic [2:0]  store_type,
   output logic        d_valid,
   output logic        d_ready,
   output logic [63:0] d_rdata,
   output logic        irq
);

   logic [2:0]              ctrl_q, ctrl_d;
   logic [63:0]             count_q, count_d;
   logic [63:0]             compare_q, compare_d;
   logic                    pending_q, pending_d;
   logic                    irq_q, irq_d;
   logic                    req_s, wr_strobe_s, rd_strobe_s, wr_ok_s, match_s;
   logic [TMR_WIN_BITS-1:0] offset_s;

   assign req_s = (|load_type) | (|store_type);

   mmio_slave_fsm #(
      .BASE_ADDR   (BASE_ADDR),
      .WAIT_CYCLES (WAIT_CYCLES),
      .WIN_BITS    (TMR_WIN_BITS)
   ) u_fsm (
      .clock       (clock),
      .reset       (reset),
      .addr_i      (addr),
      .req_i       (req_s),
      .is_write_i  (|store_type),
      .d_valid_o   (d_valid),
      .d_ready_o   (d_ready),
      .wr_strobe_o (wr_strobe_s),
      .rd_strobe_o (rd_strobe_s),
      .offset_o    (offset_s)
   );

   assign wr_ok_s = wr_strobe_s & offset_aligned(offset_s);
   assign match_s = ctrl_q[CTRL_EN] & (count_q == compare_q);
   assign irq     = irq_q;

   // Read mux, driven only during a read response
   always_comb begin
      d_rdata = 64'd0;
      if (rd_strobe_s && offset_aligned(offset_s)) begin
         case (offset_s)
            TMR_CTRL:    d_rdata = {61'd0, ctrl_q};
            TMR_COUNT:   d_rdata = count_q;
            TMR_COMPARE: d_rdata = compare_q;
            TMR_STATUS:  d_rdata = {63'd0, pending_q};
            default:     d_rdata = 64'd0;
         endcase
      end else begin
         d_rdata = 64'd0;
      end
   end

   // Counter and register next state: software COUNT write beats hardware, match-set beats W1C
   always_comb begin
      ctrl_d    = ctrl_q;
      compare_d = compare_q;
      count_d   = count_q;
      pending_d = pending_q | match_s;
      irq_d     = pending_q & ctrl_q[CTRL_IRQ_EN];
      if (ctrl_q[CTRL_EN]) begin
         if (match_s && ctrl_q[CTRL_AUTO_RELOAD]) begin
            count_d = 64'd0;
         end else begin
            count_d = count_q + 64'd1;
         end
      end else begin
         count_d = count_q;
      end
      if (wr_ok_s) begin
         case (offset_s)
            TMR_CTRL:    ctrl_d    = wdata[2:0];
            TMR_COUNT:   count_d   = wdata;
            TMR_COMPARE: compare_d = wdata;
            TMR_STATUS: begin
               if (wdata[0] && !match_s) begin
                  pending_d = 1'b0;
               end else begin
                  pending_d = pending_q | match_s;
               end
            end
            default:     ctrl_d    = ctrl_q;
         endcase
      end else begin
         ctrl_d = ctrl_q;
      end
   end

   // Timer state registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ctrl_q    <= 3'd0;
         count_q   <= 64'd0;
         compare_q <= COMPARE_RESET;
         pending_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         pending_q <= pending_d;
         irq_q     <= irq_d;
      end
   end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: default-latency instance plus a WAIT_CYCLES=3 instance.
module tb_mmio_timer;

   localparam logic [63:0] BASE = 64'h0000_0000_0001_0000;
   localparam int OP_RST = 0;
   localparam int OP_WR  = 1;
   localparam int OP_RD  = 2;

   typedef struct {
      int          op;
      logic [4:0]  off;
      logic [63:0] dat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] a_addr, a_wdata, a_rdata, b_addr, b_wdata, b_rdata;
   logic [2:0]  a_load, a_store, b_load, b_store;
   logic        a_dvalid, a_dready, a_irq, b_dvalid, b_dready, b_irq;

   int   nerr = 0;
   int   nchk = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   mmio_timer #(.BASE_ADDR(BASE), .WAIT_CYCLES(1)) u0 (
      .clock(clk), .reset(rst), .addr(a_addr), .wdata(a_wdata),
      .load_type(a_load), .store_type(a_store),
      .d_valid(a_dvalid), .d_ready(a_dready), .d_rdata(a_rdata), .irq(a_irq));

   mmio_timer #(.BASE_ADDR(BASE), .WAIT_CYCLES(3)) u3 (
      .clock(clk), .reset(rst), .addr(b_addr), .wdata(b_wdata),
      .load_type(b_load), .store_type(b_store),
      .d_valid(b_dvalid), .d_ready(b_dready), .d_rdata(b_rdata), .irq(b_irq));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic clear_types();
      a_load = 3'd0; a_store = 3'd0; b_load = 3'd0; b_store = 3'd0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_types();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Starts at posedge+1; returns at posedge+1 of the cycle after the response (or after the bound).
   task automatic access(input bit sel, input bit wr, input logic [63:0] a, input logic [63:0] wd,
                         input int drop_at, output logic [63:0] rd, output int lat, output bit v0);
      rd = 64'd0; lat = -1; v0 = 1'b0;
      if (sel) begin
         b_addr = a; b_wdata = wd;
         b_load = wr ? 3'd0 : 3'd4; b_store = wr ? 3'd4 : 3'd0;
      end else begin
         a_addr = a; a_wdata = wd;
         a_load = wr ? 3'd0 : 3'd4; a_store = wr ? 3'd4 : 3'd0;
      end
      for (int k = 0; k < 12; k++) begin
         if (k == drop_at) clear_types();
         @(negedge clk);
         if (k == 0) v0 = sel ? b_dvalid : a_dvalid;
         if ((sel ? b_dready : a_dready) && lat < 0) begin
            lat = k;
            rd  = sel ? b_rdata : a_rdata;
         end
         @(posedge clk);
         #1;
         if (lat >= 0) break;
      end
      clear_types();
   endtask

   task automatic add(input int op, input logic [4:0] off, input logic [63:0] d);
      vec_t v;
      v.op = op; v.off = off; v.dat = d;
      tbl.push_back(v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [63:0] rd;
      int          lat;
      bit          v0;
      int          first;
      bit          irq_seen [3];

      rst = 1'b1;
      a_addr = 64'd0; a_wdata = 64'd0; b_addr = 64'd0; b_wdata = 64'd0;
      clear_types();
      do_reset();

      @(negedge clk);
      chk("rst_dready", {63'd0, a_dready}, 64'd0);
      chk("rst_rdata", a_rdata, 64'd0);
      chk("rst_irq", {63'd0, a_irq}, 64'd0);
      @(posedge clk); #1;

      // Reset value of COMPARE, latency and response pulse shape
      access(1'b0, 1'b0, BASE + 64'h10, 64'd0, -1, rd, lat, v0);
      chk("t1_dvalid", {63'd0, v0}, 64'd1);
      chk("t1_lat", 64'(lat), 64'd2);
      chk("t1_rdata", rd, 64'hFFFF_FFFF_FFFF_FFFF);
      @(negedge clk);
      chk("t1_dready_after", {63'd0, a_dready}, 64'd0);
      chk("t1_rdata_after", a_rdata, 64'd0);
      @(posedge clk); #1;

      // Compare match without reload: irq rises 7 cycles after enable
      do_reset();
      access(1'b0, 1'b1, BASE + 64'h10, 64'd5, -1, rd, lat, v0);
      access(1'b0, 1'b1, BASE + 64'h00, 64'd3, -1, rd, lat, v0);
      first = -1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (a_irq && first < 0) first = n;
      end
      @(posedge clk); #1;
      chk("t2_irq_rise", 64'(first), 64'd7);
      access(1'b0, 1'b0, BASE + 64'h08, 64'd0, -1, rd, lat, v0);
      chk("t2_count", rd, 64'd12);
      access(1'b0, 1'b0, BASE + 64'h18, 64'd0, -1, rd, lat, v0);
      chk("t2_status", rd, 64'd1);

      // Wrap test, then auto-reload sequence
      add(OP_RST, 5'h00, 64'd0);
      add(OP_WR, 5'h10, 64'd10);
      add(OP_WR, 5'h08, 64'hFFFF_FFFF_FFFF_FFFE);
      add(OP_WR, 5'h00, 64'd1);
      add(OP_RD, 5'h08, 64'd0);
      add(OP_RD, 5'h18, 64'd0);
      add(OP_RD, 5'h18, 64'd0);
      add(OP_RD, 5'h18, 64'd0);
      add(OP_RD, 5'h18, 64'd1);
      add(OP_RD, 5'h08, 64'd15);
      add(OP_RD, 5'h00, 64'd1);
      add(OP_WR, 5'h08, 64'd1000);
      add(OP_RD, 5'h08, 64'd1002);
      add(OP_RST, 5'h00, 64'd0);
      add(OP_WR, 5'h10, 64'd3);
      add(OP_WR, 5'h00, 64'd7);
      add(OP_RD, 5'h08, 64'd2);
      add(OP_RD, 5'h08, 64'd1);
      add(OP_RD, 5'h08, 64'd0);
      add(OP_RD, 5'h08, 64'd3);
      add(OP_WR, 5'h18, 64'd1);
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].op == OP_RST) begin
            do_reset();
         end else begin
            access(1'b0, tbl[i].op == OP_WR, BASE + {59'd0, tbl[i].off}, tbl[i].dat, -1, rd, lat, v0);
            chk($sformatf("row%0d_lat", i), 64'(lat), 64'd2);
            if (tbl[i].op == OP_RD) chk($sformatf("row%0d_data", i), rd, tbl[i].dat);
         end
      end

      // W1C drops irq for one cycle before the next reload match re-arms it
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         irq_seen[n] = a_irq;
      end
      @(posedge clk); #1;
      chk("t3_irq_c0", {63'd0, irq_seen[0]}, 64'd1);
      chk("t3_irq_c1", {63'd0, irq_seen[1]}, 64'd0);
      chk("t3_irq_c2", {63'd0, irq_seen[2]}, 64'd1);
      repeat (3) @(posedge clk);
      #1;
      access(1'b0, 1'b1, BASE + 64'h18, 64'd1, -1, rd, lat, v0);
      chk("t3_clr_on_match_lat", 64'(lat), 64'd2);
      access(1'b0, 1'b0, BASE + 64'h18, 64'd0, -1, rd, lat, v0);
      chk("t3_clr_on_match", rd, 64'd1);

      // WAIT_CYCLES=3: abort, out-of-window, misaligned read and write
      access(1'b1, 1'b1, BASE + 64'h10, 64'h1234, 2, rd, lat, v0);
      chk("t5_abort_no_ready", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
      access(1'b1, 1'b0, BASE + 64'h10, 64'd0, -1, rd, lat, v0);
      chk("t5_lat", 64'(lat), 64'd4);
      chk("t5_compare_kept", rd, 64'hFFFF_FFFF_FFFF_FFFF);
      access(1'b1, 1'b0, BASE + 64'h20, 64'd0, -1, rd, lat, v0);
      chk("t5_out_dvalid", {63'd0, v0}, 64'd0);
      chk("t5_out_no_ready", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
      access(1'b1, 1'b0, BASE + 64'h04, 64'd0, -1, rd, lat, v0);
      chk("t5_mis_lat", 64'(lat), 64'd4);
      chk("t5_mis_data", rd, 64'd0);
      access(1'b1, 1'b1, BASE + 64'h11, 64'h55, -1, rd, lat, v0);
      chk("t5_miswr_lat", 64'(lat), 64'd4);
      access(1'b1, 1'b0, BASE + 64'h10, 64'd0, -1, rd, lat, v0);
      chk("t5_miswr_ignored", rd, 64'hFFFF_FFFF_FFFF_FFFF);

      // Reset in the middle of a WAIT phase
      access(1'b1, 1'b1, BASE + 64'h08, 64'd100, -1, rd, lat, v0);
      access(1'b1, 1'b1, BASE + 64'h10, 64'd100, -1, rd, lat, v0);
      access(1'b1, 1'b1, BASE + 64'h00, 64'd3, -1, rd, lat, v0);
      access(1'b1, 1'b0, BASE + 64'h18, 64'd0, -1, rd, lat, v0);
      chk("t6_pending_pre", rd, 64'd1);
      @(negedge clk);
      chk("t6_irq_pre", {63'd0, b_irq}, 64'd1);
      @(posedge clk); #1;
      b_addr = BASE + 64'h08; b_load = 3'd4; b_store = 3'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("t6_rst_dready", {63'd0, b_dready}, 64'd0);
      chk("t6_rst_rdata", b_rdata, 64'd0);
      chk("t6_rst_irq", {63'd0, b_irq}, 64'd0);
      clear_types();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      access(1'b1, 1'b0, BASE + 64'h08, 64'd0, -1, rd, lat, v0);
      chk("t6_post_lat", 64'(lat), 64'd4);
      chk("t6_post_count", rd, 64'd0);
      access(1'b1, 1'b0, BASE + 64'h18, 64'd0, -1, rd, lat, v0);
      chk("t6_post_status", rd, 64'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
